// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  // Controller states; RUN is the reset state and the only non-busy state.
  typedef enum logic [1:0] {
    STATE_RUN     = 2'd0,
    STATE_FLUSH   = 2'd1,
    STATE_MC_WAIT = 2'd2
  } state_e;

  // Bit positions inside stall_o (hold enables).
  localparam int STALL_PC    = 0;
  localparam int STALL_IF_ID = 1;
  localparam int STALL_ID_EX = 2;

  // Bit positions inside flush_o (bubble insert).
  localparam int FLUSH_IF_ID = 0;
  localparam int FLUSH_ID_EX = 1;

  // x0 is hard-wired zero, so writing it never creates a dependency.
  localparam logic [4:0] ZERO_REG = 5'd0;

  // A source operand depends on rd only when it is actually read.
  function automatic logic src_hit(input logic ren, input logic [4:0] rs, input logic [4:0] rd);
    return ren && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_det.sv
// Load-use hazard detect between the instruction in id and a load in ex.
// Latency: purely combinational, same cycle.
// Backpressure: none; the result only feeds the controller's stall decision.
module hazard_det
  import pipe_ctrl_pkg::*;
(
  input  logic       load,
  input  logic [4:0] rd_addr,
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  input  logic       rs1_ren,
  input  logic       rs2_ren,
  output logic       hazard
);

  // A load into x0 never produces data anyone waits for.
  always_comb begin
    hazard = load && (rd_addr != ZERO_REG) &&
             (src_hit(rs1_ren, rs1_addr, rd_addr) || src_hit(rs2_ren, rs2_addr, rd_addr));
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: jump redirect/flush, load-use bubbles, multi-cycle freeze with watchdog.
// Latency: all control outputs are combinational (0 cycles); only state/counters/mc_err_o are registered.
// Backpressure: stall_o holds pc/if_id/id_ex; optional perf counters under PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MC_TIMEOUT   = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_en_i,
  input  logic [31:0]      jump_addr_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs1_ren_i,
  input  logic             id_rs2_ren_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_load_i,
  input  logic             mc_start_i,
  input  logic             mc_done_i,
  output logic             jump_en_o,
  output logic [31:0]      jump_addr_o,
  output logic [2:0]       stall_o,
  output logic [1:0]       flush_o,
  output logic             busy_o,
  output logic             mc_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam int WAIT_W = $clog2(MC_TIMEOUT);
  localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST    = WAIT_W'(MC_TIMEOUT - 1);

  state_e            state, state_nxt;
  logic [FCNT_W-1:0] flush_cnt, flush_cnt_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              mc_err_nxt;
  logic              load_use;

  hazard_det u_hazard_det (
    .load     (ex_load_i),
    .rd_addr  (ex_rd_addr_i),
    .rs1_addr (id_rs1_addr_i),
    .rs2_addr (id_rs2_addr_i),
    .rs1_ren  (id_rs1_ren_i),
    .rs2_ren  (id_rs2_ren_i),
    .hazard   (load_use)
  );

  // State, counters and sticky error; reset aborts any flush or wait.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= STATE_RUN;
      flush_cnt <= '0;
      wait_cnt  <= '0;
      mc_err_o  <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
      mc_err_o  <= mc_err_nxt;
    end
  end

  // Next-state and control outputs; in RUN a jump beats mc_start beats load-use.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    wait_cnt_nxt  = wait_cnt;
    mc_err_nxt    = mc_err_o;
    jump_en_o     = 1'b0;
    jump_addr_o   = '0;
    stall_o       = '0;
    flush_o       = '0;
    case (state)
      STATE_RUN: begin
        jump_en_o   = jump_en_i;
        jump_addr_o = jump_addr_i;
        if (jump_en_i) begin
          flush_o[FLUSH_IF_ID] = 1'b1;
          flush_o[FLUSH_ID_EX] = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt     = STATE_FLUSH;
            flush_cnt_nxt = FLUSH_RELOAD;
          end
        end else if (mc_start_i) begin
          stall_o      = 3'b111;
          state_nxt    = STATE_MC_WAIT;
          wait_cnt_nxt = '0;
        end else if (load_use) begin
          // Hold pc and if_id, let the load advance and put a bubble into id_ex.
          stall_o[STALL_PC]    = 1'b1;
          stall_o[STALL_IF_ID] = 1'b1;
          flush_o[FLUSH_ID_EX] = 1'b1;
        end
      end
      STATE_FLUSH: begin
        jump_en_o   = jump_en_i;
        jump_addr_o = jump_addr_i;
        flush_o     = 2'b11;
        if (jump_en_i) begin
          flush_cnt_nxt = FLUSH_RELOAD;
        end else if (flush_cnt == FCNT_W'(1)) begin
          flush_cnt_nxt = '0;
          state_nxt     = STATE_RUN;
        end else begin
          flush_cnt_nxt = flush_cnt - FCNT_W'(1);
        end
      end
      STATE_MC_WAIT: begin
        // ex is frozen, so any jump/mc_start seen here is stale and ignored.
        stall_o = 3'b111;
        if (mc_done_i) begin
          stall_o   = '0;
          state_nxt = STATE_RUN;
        end else if (wait_cnt == WAIT_LAST) begin
          mc_err_nxt = 1'b1;
          state_nxt  = STATE_RUN;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      default: begin
        state_nxt = STATE_RUN;
      end
    endcase
  end

  assign busy_o = (state != STATE_RUN);

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating counts of stalled-pc cycles and cycles with any flush active.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_o[STALL_PC] && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if ((flush_o != 2'b00) && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: dut_a (FLUSH_CYCLES=2, MC_TIMEOUT=64), dut_b (FLUSH_CYCLES=1, MC_TIMEOUT=8).
// Latency: checks sampled 1ns after each falling-edge drive.
// Backpressure: n/a.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
  logic        id_rs1_ren_i, id_rs2_ren_i, ex_load_i, mc_start_i, mc_done_i;

  logic        jump_en_a, busy_a, err_a, jump_en_b, busy_b, err_b;
  logic [31:0] jump_addr_a, jump_addr_b, scnt_a, fcnt_a, scnt_b, fcnt_b;
  logic [2:0]  stall_a, stall_b;
  logic [1:0]  flush_a, flush_b;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(2), .MC_TIMEOUT(64), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_ren_i(id_rs1_ren_i), .id_rs2_ren_i(id_rs2_ren_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_load_i(ex_load_i),
    .mc_start_i(mc_start_i), .mc_done_i(mc_done_i),
    .jump_en_o(jump_en_a), .jump_addr_o(jump_addr_a), .stall_o(stall_a), .flush_o(flush_a),
    .busy_o(busy_a), .mc_err_o(err_a), .stall_cnt_o(scnt_a), .flush_cnt_o(fcnt_a)
  );

  pipe_ctrl #(.FLUSH_CYCLES(1), .MC_TIMEOUT(8), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_ren_i(id_rs1_ren_i), .id_rs2_ren_i(id_rs2_ren_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_load_i(ex_load_i),
    .mc_start_i(mc_start_i), .mc_done_i(mc_done_i),
    .jump_en_o(jump_en_b), .jump_addr_o(jump_addr_b), .stall_o(stall_b), .flush_o(flush_b),
    .busy_o(busy_b), .mc_err_o(err_b), .stall_cnt_o(scnt_b), .flush_cnt_o(fcnt_b)
  );

  typedef struct {
    string      name;
    logic       ld;
    logic [4:0] rd, rs1, rs2;
    logic       r1en, r2en;
    logic [2:0] exp_stall;
    logic [1:0] exp_flush;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(input string name, input logic ld, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic r1en,
                              input logic r2en, input logic [2:0] es, input logic [1:0] ef);
    vec_t v;
    v.name = name; v.ld = ld; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.r1en = r1en; v.r2en = r2en; v.exp_stall = es; v.exp_flush = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic idle();
    jump_en_i = 1'b0; jump_addr_i = '0; id_rs1_addr_i = '0; id_rs2_addr_i = '0;
    id_rs1_ren_i = 1'b0; id_rs2_ren_i = 1'b0; ex_rd_addr_i = '0; ex_load_i = 1'b0;
    mc_start_i = 1'b0; mc_done_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_s, exp_f;
    vecs[0] = mk("idle",          1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 3'b000, 2'b00);
    vecs[1] = mk("rs2_match",     1'b1, 5'd5,  5'd3,  5'd5,  1'b1, 1'b1, 3'b011, 2'b10);
    vecs[2] = mk("rd_x0",         1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 3'b000, 2'b00);
    vecs[3] = mk("rs1_match",     1'b1, 5'd7,  5'd7,  5'd2,  1'b1, 1'b0, 3'b011, 2'b10);
    vecs[4] = mk("match_no_ren",  1'b1, 5'd7,  5'd7,  5'd7,  1'b0, 1'b0, 3'b000, 2'b00);
    vecs[5] = mk("not_load",      1'b0, 5'd9,  5'd9,  5'd9,  1'b1, 1'b1, 3'b000, 2'b00);
    vecs[6] = mk("mismatch",      1'b1, 5'd12, 5'd13, 5'd11, 1'b1, 1'b1, 3'b000, 2'b00);
    vecs[7] = mk("rs2_no_ren",    1'b1, 5'd31, 5'd30, 5'd31, 1'b1, 1'b0, 3'b000, 2'b00);
    vecs[8] = mk("both_match",    1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 3'b011, 2'b10);

    do_reset();
    #1;
    chk("rst_stall", {29'd0, stall_a}, 32'd0);
    chk("rst_flush", {30'd0, flush_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_err", {31'd0, err_a}, 32'd0);
    chk("rst_jump_en", {31'd0, jump_en_a}, 32'd0);
    chk("rst_scnt", scnt_a, 32'd0);

    // Load-use table in RUN
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      ex_load_i = vecs[i].ld; ex_rd_addr_i = vecs[i].rd;
      id_rs1_addr_i = vecs[i].rs1; id_rs2_addr_i = vecs[i].rs2;
      id_rs1_ren_i = vecs[i].r1en; id_rs2_ren_i = vecs[i].r2en;
      #1;
      chk({vecs[i].name, "_stall_a"}, {29'd0, stall_a}, {29'd0, vecs[i].exp_stall});
      chk({vecs[i].name, "_flush_a"}, {30'd0, flush_a}, {30'd0, vecs[i].exp_flush});
      chk({vecs[i].name, "_stall_b"}, {29'd0, stall_b}, {29'd0, vecs[i].exp_stall});
      chk({vecs[i].name, "_busy_a"}, {31'd0, busy_a}, 32'd0);
    end

    // Priority: mc_start over load-use, then jump over everything
    do_reset();
    ex_load_i = 1'b1; ex_rd_addr_i = 5'd5; id_rs2_addr_i = 5'd5; id_rs2_ren_i = 1'b1;
    jump_en_i = 1'b1; jump_addr_i = 32'h0000_0300; mc_start_i = 1'b1;
    #1;
    chk("prio_jump_stall", {29'd0, stall_a}, 32'd0);
    chk("prio_jump_flush", {30'd0, flush_a}, 32'd3);
    jump_en_i = 1'b0;
    #1;
    chk("prio_mc_stall", {29'd0, stall_a}, 32'd7);
    chk("prio_mc_flush", {30'd0, flush_a}, 32'd0);

    // Jump: dut_a flushes 2 cycles, dut_b 1 cycle
    do_reset();
    jump_en_i = 1'b1; jump_addr_i = 32'h0000_0100;
    #1;
    chk("jmp_en_c0", {31'd0, jump_en_a}, 32'd1);
    chk("jmp_addr_c0", jump_addr_a, 32'h0000_0100);
    chk("jmp_flush_c0", {30'd0, flush_a}, 32'd3);
    chk("jmp_stall_c0", {29'd0, stall_a}, 32'd0);
    chk("jmp_busy_c0", {31'd0, busy_a}, 32'd0);
    chk("jmp_b_flush_c0", {30'd0, flush_b}, 32'd3);
    @(negedge clk); idle(); #1;
    chk("jmp_flush_c1", {30'd0, flush_a}, 32'd3);
    chk("jmp_busy_c1", {31'd0, busy_a}, 32'd1);
    chk("jmp_en_c1", {31'd0, jump_en_a}, 32'd0);
    chk("jmp_b_flush_c1", {30'd0, flush_b}, 32'd0);
    chk("jmp_b_busy_c1", {31'd0, busy_b}, 32'd0);
    @(negedge clk); #1;
    chk("jmp_flush_c2", {30'd0, flush_a}, 32'd0);
    chk("jmp_busy_c2", {31'd0, busy_a}, 32'd0);

    // Multi-cycle: done 10 cycles after start; dut_b times out meanwhile
    do_reset();
    mc_start_i = 1'b1; #1;
    chk("mc_stall_c0", {29'd0, stall_a}, 32'd7);
    @(negedge clk); mc_start_i = 1'b0;
    for (int c = 1; c < 10; c++) begin
      jump_en_i = (c == 5); jump_addr_i = (c == 5) ? 32'h0000_0200 : 32'd0;
      #1;
      chk($sformatf("mc_stall_c%0d", c), {29'd0, stall_a}, 32'd7);
      chk($sformatf("mc_busy_c%0d", c), {31'd0, busy_a}, 32'd1);
      if (c == 5) begin
        chk("mc_jump_ign_a", {31'd0, jump_en_a}, 32'd0);
        chk("mc_jump_ign_b", {31'd0, jump_en_b}, 32'd0);
      end
      if (c == 8) chk("to_err_before", {31'd0, err_b}, 32'd0);
      if (c == 9) begin
        chk("to_err_after", {31'd0, err_b}, 32'd1);
        chk("to_busy_after", {31'd0, busy_b}, 32'd0);
      end
      @(negedge clk);
    end
    idle(); mc_done_i = 1'b1; #1;
    chk("mc_done_stall", {29'd0, stall_a}, 32'd0);
    @(negedge clk); idle(); #1;
    chk("mc_after_busy", {31'd0, busy_a}, 32'd0);
    chk("mc_after_err", {31'd0, err_a}, 32'd0);
    chk("to_err_sticky", {31'd0, err_b}, 32'd1);

    // Done and timeout in the same cycle on dut_b: no error
    do_reset();
    mc_start_i = 1'b1;
    @(negedge clk); mc_start_i = 1'b0;
    repeat (7) @(negedge clk);
    mc_done_i = 1'b1; #1;
    chk("dt_stall_b", {29'd0, stall_b}, 32'd0);
    @(negedge clk); idle(); #1;
    chk("dt_err_b", {31'd0, err_b}, 32'd0);
    chk("dt_busy_b", {31'd0, busy_b}, 32'd0);

    // Asynchronous reset mid-MC_WAIT clears state and sticky error
    do_reset();
    mc_start_i = 1'b1;
    @(negedge clk); mc_start_i = 1'b0;
    repeat (11) @(negedge clk);
    #1;
    chk("ar_busy_pre", {31'd0, busy_a}, 32'd1);
    chk("ar_err_b_pre", {31'd0, err_b}, 32'd1);
    rst = 1'b0; #1;
    chk("ar_busy", {31'd0, busy_a}, 32'd0);
    chk("ar_stall", {29'd0, stall_a}, 32'd0);
    chk("ar_flush", {30'd0, flush_a}, 32'd0);
    chk("ar_err_a", {31'd0, err_a}, 32'd0);
    chk("ar_err_b", {31'd0, err_b}, 32'd0);
    @(negedge clk); rst = 1'b1;

    // Perf counters: 3 stalled cycles, then a jump
    do_reset();
    mc_start_i = 1'b1;
    @(negedge clk); mc_start_i = 1'b0;
    repeat (2) @(negedge clk);
    mc_done_i = 1'b1;
    @(negedge clk); mc_done_i = 1'b0; jump_en_i = 1'b1; jump_addr_i = 32'h40;
    @(negedge clk); idle();
    @(negedge clk); #1;
`ifdef PIPE_CTRL_PERF_EN
    exp_s = 32'd3; exp_f = 32'd1;
`else
    exp_s = 32'd0; exp_f = 32'd0;
`endif
    chk("perf_stall_b", scnt_b, exp_s);
    chk("perf_flush_b", fcnt_b, exp_f);
    chk("perf_stall_a", scnt_a, exp_s);
    chk("perf_flush_a", fcnt_a, exp_f + exp_f);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
